// File: rtl/uart_pkg.sv
// Shared types and default sizing for the uart_tx_queue slice.
// UART_TXQ_TIMEOUT_EN (in uart_tx_queue) enables the per-frame abort timer.
package uart_pkg;

  localparam int DEPTH_DEF       = 16;
  localparam int ADDR_W_DEF      = 4;
  localparam int TIMEOUT_CYC_DEF = 4096;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARM       = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// Circular byte store with read/write pointers and an occupancy counter.
// Pointers wrap naturally because DEPTH is a power of two.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  byte_t             i_wdata,
  output byte_t             o_rdata,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_empty
);

  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_FULL = DEPTH[ADDR_W:0];

  byte_t             r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;

  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Push and pop together leave the occupancy unchanged.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= {ADDR_W{1'b0}};
      r_rd_ptr <= {ADDR_W{1'b0}};
      r_count  <= {(ADDR_W+1){1'b0}};
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CNT_FULL);
  assign o_empty = (r_count == {(ADDR_W+1){1'b0}});

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding uart_tx: one SEND pulse per frame, waits on NINTO completion.
// Define UART_TXQ_TIMEOUT_EN to abort frames that exceed TIMEOUT_CYC cycles.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              CLOCK_TX,
  input  logic              RESET,
  input  logic              WR_EN,
  input  logic [7:0]        WR_DATA,
  input  logic              OVF_CLR,
  input  logic              NINTO,
  output logic              SEND,
  output logic [7:0]        TX_DATA,
  output logic              FULL,
  output logic              EMPTY,
  output logic [ADDR_W:0]   COUNT,
  output logic              BUSY,
  output logic              OVERFLOW,
  output logic              TIMEOUT
);

  state_e r_state;
  state_e w_state_norm;
  state_e w_state_nxt;
  byte_t  w_rdata;
  logic   w_pop;
  logic   w_push;
  logic   w_ovf_evt;
  logic   w_tmo_hit;
  logic   r_send;
  byte_t  r_tx_data;
  logic   r_overflow;

  // A full queue still accepts a write when the head leaves in the same cycle.
  assign w_pop     = (r_state == IDLE) && !EMPTY;
  assign w_push    = WR_EN && (!FULL || w_pop);
  assign w_ovf_evt = WR_EN && FULL && !w_pop;

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .i_clk   (CLOCK_TX),
    .i_rst   (RESET),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (WR_DATA),
    .o_rdata (w_rdata),
    .o_count (COUNT),
    .o_full  (FULL),
    .o_empty (EMPTY)
  );

`ifdef UART_TXQ_TIMEOUT_EN
  localparam int TCNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 2;
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT_CYC - 32'sd1);
  localparam logic [TCNT_W-1:0] TCNT_ONE = {{(TCNT_W-1){1'b0}}, 1'b1};

  logic [TCNT_W-1:0] r_tcnt;
  logic              r_timeout;

  assign w_tmo_hit = (r_state != IDLE) && (r_tcnt == TCNT_MAX);

  // Frame age counter restarts at each launch; an expired frame is dropped.
  always_ff @(posedge CLOCK_TX) begin
    if (RESET) begin
      r_tcnt    <= {TCNT_W{1'b0}};
      r_timeout <= 1'b0;
    end else begin
      if (w_pop) begin
        r_tcnt <= {TCNT_W{1'b0}};
      end else if (r_state != IDLE) begin
        r_tcnt <= r_tcnt + TCNT_ONE;
      end
      if (w_tmo_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign TIMEOUT = r_timeout;
`else
  assign w_tmo_hit = 1'b0;
  assign TIMEOUT   = 1'b0;
`endif

  // ARM ignores a stale-low NINTO until uart_tx reports the frame in flight.
  always_comb begin
    w_state_norm = r_state;
    case (r_state)
      IDLE:      w_state_norm = w_pop ? ARM : IDLE;
      ARM:       w_state_norm = NINTO ? WAIT_DONE : ARM;
      WAIT_DONE: w_state_norm = NINTO ? WAIT_DONE : IDLE;
      default:   w_state_norm = IDLE;
    endcase
    w_state_nxt = w_tmo_hit ? IDLE : w_state_norm;
  end

  always_ff @(posedge CLOCK_TX) begin
    if (RESET) begin
      r_state    <= IDLE;
      r_send     <= 1'b0;
      r_tx_data  <= 8'h00;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_send  <= w_pop;
      if (w_pop) begin
        r_tx_data <= w_rdata;
      end
      if (w_ovf_evt) begin
        r_overflow <= 1'b1;
      end else if (OVF_CLR) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign SEND     = r_send;
  assign TX_DATA  = r_tx_data;
  assign BUSY     = (r_state != IDLE);
  assign OVERFLOW = r_overflow;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_uart_tx_queue;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int TCYC   = 64;

  logic              CLOCK_TX = 1'b0;
  logic              RESET    = 1'b1;
  logic              WR_EN    = 1'b0;
  logic [7:0]        WR_DATA  = 8'h00;
  logic              OVF_CLR  = 1'b0;
  logic              NINTO    = 1'b0;
  logic              SEND;
  logic [7:0]        TX_DATA;
  logic              FULL;
  logic              EMPTY;
  logic [ADDR_W:0]   COUNT;
  logic              BUSY;
  logic              OVERFLOW;
  logic              TIMEOUT;

  uart_tx_queue #(
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TCYC)
  ) dut (
    .CLOCK_TX (CLOCK_TX),
    .RESET    (RESET),
    .WR_EN    (WR_EN),
    .WR_DATA  (WR_DATA),
    .OVF_CLR  (OVF_CLR),
    .NINTO    (NINTO),
    .SEND     (SEND),
    .TX_DATA  (TX_DATA),
    .FULL     (FULL),
    .EMPTY    (EMPTY),
    .COUNT    (COUNT),
    .BUSY     (BUSY),
    .OVERFLOW (OVERFLOW),
    .TIMEOUT  (TIMEOUT)
  );

  always #5 CLOCK_TX = ~CLOCK_TX;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending bytes, frame phase (0 none, 1 launched, 2 in flight).
  logic [7:0] m_q[$];
  int         m_phase = 0;
  logic       m_send  = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       m_ovf   = 1'b0;
  logic       m_tmo   = 1'b0;
  int         m_tcnt  = 0;

  // Emulated uart_tx: NINTO high from 2 cycles after SEND for u_len cycles.
  int u_cnt  = -1;
  int u_len  = 5;
  logic u_rand = 1'b0;

  logic [7:0] sent[$];
  int n_send;
  int max_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic wr, input logic [7:0] d,
                      input logic clr, input logic nin);
    logic pop;
    int   nxt;
    RESET = rst; WR_EN = wr; WR_DATA = d; OVF_CLR = clr; NINTO = nin;
    @(posedge CLOCK_TX);
    if (rst) begin
      m_q.delete();
      m_phase = 0; m_send = 1'b0; m_data = 8'h00;
      m_ovf = 1'b0; m_tmo = 1'b0; m_tcnt = 0;
    end else begin
      pop    = (m_phase == 0) && (m_q.size() != 0);
      m_send = pop;
      if (wr && (m_q.size() == DEPTH) && !pop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (pop) m_data = m_q.pop_front();
      if (wr && (m_q.size() < DEPTH)) m_q.push_back(d);
      if (pop) begin
        m_phase = 1;
        m_tcnt  = 0;
      end else if (m_phase != 0) begin
        nxt = m_phase;
        if (m_phase == 1 && nin) nxt = 2;
        else if (m_phase == 2 && !nin) nxt = 0;
`ifdef UART_TXQ_TIMEOUT_EN
        if (m_tcnt == TCYC - 1) begin
          nxt   = 0;
          m_tmo = 1'b1;
        end
        m_tcnt++;
`endif
        m_phase = nxt;
      end
    end
    #1;
    check("send",     SEND,     m_send);
    check("tx_data",  TX_DATA,  m_data);
    check("count",    COUNT,    m_q.size());
    check("full",     FULL,     m_q.size() == DEPTH);
    check("empty",    EMPTY,    m_q.size() == 0);
    check("busy",     BUSY,     m_phase != 0);
    check("overflow", OVERFLOW, m_ovf);
    check("timeout",  TIMEOUT,  m_tmo);
    if (SEND) begin
      sent.push_back(TX_DATA);
      n_send++;
    end
    if (COUNT > max_cnt) max_cnt = COUNT;
  endtask

  task automatic ucycle(input logic wr, input logic [7:0] d, input logic clr);
    logic nin;
    nin = (u_cnt >= 2) && (u_cnt < 2 + u_len);
    step(1'b0, wr, d, clr, nin);
    if (m_send) begin
      u_cnt = 0;
      if (u_rand) u_len = $urandom_range(1, 12);
    end else if (u_cnt >= 0 && u_cnt < 100000) begin
      u_cnt++;
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    u_cnt = -1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (m_q.size() == 0 && m_phase == 0) break;
      ucycle(1'b0, 8'h00, 1'b0);
    end
    check("drained", BUSY | (COUNT != 0), 1'b0);
  endtask

  initial begin
    int k;
    @(posedge CLOCK_TX); #1;

    // Reset state, with a write attempt that reset must override.
    step(1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
    check("rst_count", COUNT, 0);
    u_cnt = -1;

    // Single byte with a long frame.
    u_len = 100; n_send = 0; sent.delete();
    ucycle(1'b1, 8'hA5, 1'b0);
    check("single_count1", COUNT, 1);
    for (int i = 0; i < 110; i++) ucycle(1'b0, 8'h00, 1'b0);
    check("single_nsend", n_send, 1);
    check("single_byte", sent[0], 8'hA5);
    check("single_idle", BUSY, 1'b0);

    // Burst of 20 bytes across frames, forcing pointer wrap.
    u_len = 4; sent.delete(); max_cnt = 0; k = 0;
    for (int i = 0; i < 400 && k < 20; i++) begin
      if (m_q.size() < DEPTH) begin
        ucycle(1'b1, k[7:0], 1'b0);
        k++;
      end else begin
        ucycle(1'b0, 8'h00, 1'b0);
      end
    end
    drain(400);
    check("burst_nsent", sent.size(), 20);
    for (int i = 0; i < 20 && i < sent.size(); i++) check("burst_order", sent[i], i);
    check("burst_ovf", OVERFLOW, 1'b0);
    check("burst_maxcnt", max_cnt <= DEPTH, 1'b1);

    // Overflow with the frame stuck in flight.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 1'b1, 8'h40 + i[7:0], 1'b0, 1'b1);
      if (i == 16) check("ovf_full17", FULL, 1'b1);
    end
    check("ovf_set", OVERFLOW, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("ovf_clr", OVERFLOW, 1'b0);
    step(1'b0, 1'b1, 8'h99, 1'b1, 1'b1);
    check("ovf_wins", OVERFLOW, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Simultaneous push and pop at full.
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("pp_idle", BUSY, 1'b0);
    step(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
    check("pp_send", SEND, 1'b1);
    check("pp_data", TX_DATA, 8'h41);
    check("pp_count", COUNT, 16);
    check("pp_full", FULL, 1'b1);
    u_cnt = 0;
    drain(400);

    // Stale-low NINTO must not complete the next frame.
    n_send = 0;
    step(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("stale_send", SEND, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("stale_arm", BUSY, 1'b1);
    check("stale_nsend", n_send, 1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("stale_done", BUSY, 1'b0);

    // Reset in WAIT_DONE with 5 bytes queued.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'hC0 + i[7:0], 1'b0, 1'b1);
    check("midrst_q5", COUNT, 5);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check("midrst_cnt", COUNT, 0);
    check("midrst_data", TX_DATA, 8'h00);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("midrst_nosend", SEND, 1'b0);

    // Frame stuck high long enough to expire an enabled timeout.
    step(1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h22, 1'b0, 1'b1);
    for (int i = 0; i < TCYC + 8; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    do_reset();

    // Random traffic against the model.
    u_rand = 1'b1; u_len = 5;
    for (int i = 0; i < 600; i++) begin
      ucycle(($urandom_range(0, 2) == 0), 8'($urandom), ($urandom_range(0, 15) == 0));
    end
    drain(600);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before 2000000");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
- Transmit-side feeder placed directly upstream of uart_tx in the CLOCK_TX domain.
- Buffers bytes from a host write port in a circular FIFO.
- Drains one byte per frame: drives TX_DATA and a one-cycle SEND pulse into uart_tx, then waits on uart_tx's active-low NINTO completion indication before launching the next byte.

Parameters:
- DEPTH, 16, FIFO entries (power of two, ≥2).
- ADDR_W, 4, log2(DEPTH).
- TIMEOUT_CYC, 4096, CLOCK_TX cycles allowed per frame before abort (used only with UART_TXQ_TIMEOUT_EN).

Ports:
- CLOCK_TX  in  1  single clock, rising edge.
- RESET  in  1  synchronous, active-high.
- WR_EN  in  1  host write strobe.
- WR_DATA  in  8  host byte.
- OVF_CLR  in  1  clears OVERFLOW.
- NINTO  in  1  from uart_tx; high while a frame is in flight, low on frame completion.
- SEND  out  1  one-cycle launch pulse to uart_tx.
- TX_DATA  out  8  byte to uart_tx, held stable between launches.
- FULL  out  1  COUNT == DEPTH.
- EMPTY  out  1  COUNT == 0.
- COUNT  out  ADDR_W+1  stored entries.
- BUSY  out  1  state != IDLE.
- OVERFLOW  out  1  sticky: write dropped.
- TIMEOUT  out  1  sticky: frame aborted (0 when feature absent).

Behaviour:
- Clocking and reset:
  - All state is updated on the rising edge of CLOCK_TX.
  - RESET is synchronous and active-high; it dominates every other input.
  - Reset values: pointers 0, COUNT 0, EMPTY 1, FULL 0, SEND 0, TX_DATA 8'h00, BUSY 0, OVERFLOW 0, TIMEOUT 0, state IDLE.
  - Reset mid-frame discards all queued data. No SEND is issued in the cycle after reset.
- Write:
  - Accepted when WR_EN and (COUNT < DEPTH or a pop occurs in the same cycle).
  - On accept: mem[wr_ptr] ← WR_DATA, wr_ptr increments modulo DEPTH.
  - WR_EN while full with no pop: byte dropped, OVERFLOW ← 1.
  - OVF_CLR clears OVERFLOW. A simultaneous new overflow wins.
- Pop:
  - Occurs only in IDLE with EMPTY = 0.
  - TX_DATA ← mem[rd_ptr]; SEND ← 1 for exactly one cycle; rd_ptr increments modulo DEPTH.
- COUNT:
  - +1 on write only, −1 on pop only, unchanged on simultaneous write and pop.
  - Never exceeds DEPTH; never goes below 0.
- State machine (registered):
  - IDLE: if not EMPTY → pop, go to ARM.
  - ARM: wait for NINTO = 1 (uart_tx has accepted the byte and is busy) → WAIT_DONE.
  - WAIT_DONE: wait for NINTO = 0 → IDLE.
  - The ARM stage guarantees a stale-low NINTO from the previous frame is never taken as completion, whether uart_tx drives NINTO as a pulse or as a level.
- Latency:
  - A byte written on edge k into an empty queue in IDLE produces SEND high during the cycle after edge k+1.
  - Back-to-back frames: the next SEND follows one cycle after the IDLE return.
- Boundaries:
  - Pointer wrap at DEPTH−1 → 0.
  - Writes accepted while a frame is in flight.
  - WR_EN while EMPTY with a pop pending is impossible: a pop requires not EMPTY.
  - NINTO glitches in IDLE are ignored.

Optional Feature:
- Macro: UART_TXQ_TIMEOUT_EN.
- With the macro:
  - A counter clears on SEND and increments in ARM and WAIT_DONE.
  - On reaching TIMEOUT_CYC − 1: TIMEOUT ← 1 (sticky until RESET), state → IDLE.
  - The popped byte is lost, not retried.
- Without the macro: no counter; TIMEOUT is tied 0; the queue waits on NINTO indefinitely.

Decomposition:
- Shared package uart_pkg: state enum (IDLE, ARM, WAIT_DONE), default DEPTH/ADDR_W/TIMEOUT_CYC constants, byte type.
- One natural sub-module, uart_fifo_mem: storage array, wr/rd pointers, COUNT/FULL/EMPTY.
- Control FSM, SEND/TX_DATA registers, OVERFLOW and TIMEOUT stay in the top block.

Test Plan:
- Single byte: reset, write 8'hA5 to the empty queue; model uart_tx (NINTO high 2 cycles after SEND, low 1 cycle after 100 cycles) → exactly one SEND pulse, TX_DATA = 8'hA5, COUNT 1→0, BUSY low after NINTO low.
- Burst and wrap: write 20 bytes 8'h00..8'h13 with DEPTH=16 across frames → bytes sent in order, FIFO wraps, no OVERFLOW; COUNT never exceeds 16.
- Overflow: hold NINTO high (frame stuck), write 18 bytes → FULL after 17 (1 popped plus 16 stored), byte 18 dropped, OVERFLOW = 1; pulse OVF_CLR → 0.
- Simultaneous push/pop at full: full queue, IDLE, WR_EN in the pop cycle → write accepted, COUNT stays 16, FULL stays 1.
- Stale NINTO: NINTO held low from the previous frame, new write → SEND issued, FSM holds in ARM until NINTO rises, no premature second SEND.
- Reset mid-frame and timeout: RESET in WAIT_DONE with 5 bytes queued → all outputs at reset values next cycle. With UART_TXQ_TIMEOUT_EN and TIMEOUT_CYC=64, NINTO stuck high → TIMEOUT = 1 at cycle 64 after SEND, next byte launched.
